pipe_stage_reg: RTL
===================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, bit width of one data channel.
REQ-002 SHALL have parameter NCH, default 2, number of data channels; legal range 1..8.
REQ-003 SHALL have parameter CNTW, default 16, width of each statistics counter.
REQ-004 SHALL have port ref_clk  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  in  1  reset, synchronous and active-low.
REQ-006 SHALL have port flush  in  1  active-high synchronous clear of all stage contents.
REQ-007 SHALL have port in_valid  in  1  upstream data valid.
REQ-008 SHALL have port in_ready  out  1  stage can accept data this cycle.
REQ-009 SHALL have port data_i  in  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 SHALL have port out_valid  out  1  downstream data valid.
REQ-011 SHALL have port out_ready  in  1  downstream accepts data.
REQ-012 SHALL have port data_o  out  NCH*WIDTH  registered channel data, same packing as data_i.
REQ-013 SHALL have port stall_cnt  out  CNTW  count of back-pressured cycles.
REQ-014 SHALL have port bubble_cnt  out  CNTW  count of empty cycles with downstream ready.

Function
REQ-015 SHALL hold a main entry (drives data_o) and a one-entry skid entry, each with a valid bit.
REQ-016 SHALL implement states EMPTY (no valid entry), ONE (main valid only), FULL (main and skid valid).
REQ-017 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-018 SHALL drive in_ready = 1 in EMPTY and ONE, 0 in FULL; in_ready is a decode of registered state only, never of out_ready.
REQ-019 SHALL drive out_valid = 1 in ONE and FULL, 0 in EMPTY.
REQ-020 SHALL drive data_o = main data when out_valid = 1, all-zero when out_valid = 0.
REQ-021 EMPTY: in_fire -> main <= data_i, go ONE; otherwise stay EMPTY.
REQ-022 ONE: in_fire & out_fire -> main <= data_i, stay ONE; in_fire only -> skid <= data_i, go FULL; out_fire only -> go EMPTY; neither -> hold.
REQ-023 FULL: out_fire -> main <= skid, skid invalid, go ONE; otherwise hold both entries unchanged.
REQ-024 SHALL give 1-cycle latency: data accepted at edge N appears on data_o after edge N when the stage was EMPTY.
REQ-025 SHALL sustain one transfer per cycle when out_ready is held 1; no data lost or duplicated under any in_valid/out_ready pattern.
REQ-026 SHALL preserve order: skid data always leaves after main data.
REQ-027 flush = 1 at an edge SHALL clear both valid bits and both data entries to zero and go EMPTY; an in_fire in the same cycle is discarded; an out_fire in the same cycle counts as delivered downstream.
REQ-028 stall_cnt SHALL increment by 1 each cycle with out_valid = 1 and out_ready = 0, saturating at 2^CNTW-1.
REQ-029 bubble_cnt SHALL increment by 1 each cycle with out_valid = 0 and out_ready = 1, saturating at 2^CNTW-1.
REQ-030 flush SHALL NOT clear stall_cnt or bubble_cnt; the flush cycle itself still counts per REQ-028/029 using pre-flush out_valid.

Reset
REQ-031 reset_n = 0 at an edge SHALL force EMPTY, clear both entries to zero, and clear stall_cnt and bubble_cnt to 0; reset has priority over flush and all handshakes.
REQ-032 After reset: in_ready = 1, out_valid = 0, data_o = 0, stall_cnt = 0, bubble_cnt = 0.
REQ-033 Reset asserted while FULL SHALL discard both entries; no transfer occurs in that cycle.

Verification
REQ-034 Pass-through: out_ready = 1, in_valid = 1, data_i = {32'h0, 32'h7FF} then {32'h1, 32'h0} -> data_o shows each value exactly one cycle after accept; bubble_cnt = 1 after first cycle.
REQ-035 Back-pressure: out_ready = 0, push 32'hA then 32'hB -> state FULL, in_ready = 0, data_o = A; raise out_ready -> A then B delivered in order, stall_cnt = cycles out_ready was low with out_valid = 1.
REQ-036 Flush: FULL with A, B, assert flush with in_valid = 1, data C -> next cycle out_valid = 0, data_o = 0, C never appears; counters unchanged.
REQ-037 Reset mid-operation: FULL, reset_n = 0 one cycle -> all outputs at reset values; reset with flush = 1 same cycle gives identical result.
REQ-038 Saturation: CNTW = 4, out_valid = 1, out_ready = 0 for 20 cycles -> stall_cnt stops at 15.
REQ-039 Random: NCH = 3, WIDTH = 8, random in_valid/out_ready 10000 cycles -> scoreboard output sequence equals input sequence.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Two-entry valid/ready pipeline register with skid buffer.
// Tracks back-pressure and bubble cycles in saturating counters.
module pipe_stage_reg #(
    parameter int WIDTH = 32,
    parameter int NCH   = 2,
    parameter int CNTW  = 16
) (
    input  logic                  ref_clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NCH*WIDTH-1:0]  data_i,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NCH*WIDTH-1:0]  data_o,
    output logic [CNTW-1:0]       stall_cnt,
    output logic [CNTW-1:0]       bubble_cnt
);

    localparam int DW = NCH * WIDTH;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [DW-1:0]   r_main;
    logic [DW-1:0]   r_skid;
    logic [DW-1:0]   w_main_nx;
    logic [DW-1:0]   w_skid_nx;
    logic [CNTW-1:0] r_stall;
    logic [CNTW-1:0] r_bubble;
    logic            w_in_fire;
    logic            w_out_fire;
    logic            w_stall_inc;
    logic            w_bubble_inc;

    // Handshake flags decode registered state only.
    assign in_ready     = (r_state != S_FULL);
    assign out_valid    = (r_state != S_EMPTY);
    assign data_o       = out_valid ? r_main : '0;
    assign w_in_fire    = in_valid & in_ready;
    assign w_out_fire   = out_valid & out_ready;
    assign w_stall_inc  = out_valid & ~out_ready;
    assign w_bubble_inc = ~out_valid & out_ready;
    assign stall_cnt    = r_stall;
    assign bubble_cnt   = r_bubble;

    // Next-state and entry updates for the EMPTY/ONE/FULL occupancy FSM.
    always_comb begin
        w_state_nx = r_state;
        w_main_nx  = r_main;
        w_skid_nx  = r_skid;
        unique case (r_state)
            S_EMPTY: begin
                if (w_in_fire) begin
                    w_main_nx  = data_i;
                    w_state_nx = S_ONE;
                end
            end
            S_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_nx = data_i;
                end else if (w_in_fire) begin
                    w_skid_nx  = data_i;
                    w_state_nx = S_FULL;
                end else if (w_out_fire) begin
                    w_state_nx = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_out_fire) begin
                    w_main_nx  = r_skid;
                    w_skid_nx  = '0;
                    w_state_nx = S_ONE;
                end
            end
            default: begin
                w_state_nx = S_EMPTY;
            end
        endcase
    end

    // State and entry registers; reset beats flush, flush beats handshakes.
    always_ff @(posedge ref_clk) begin
        if (!reset_n) begin
            r_state <= S_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else if (flush) begin
            r_state <= S_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_main  <= w_main_nx;
            r_skid  <= w_skid_nx;
        end
    end

    // Saturating statistics; flush leaves them alone.
    always_ff @(posedge ref_clk) begin
        if (!reset_n) begin
            r_stall  <= '0;
            r_bubble <= '0;
        end else begin
            if (w_stall_inc && (r_stall != {CNTW{1'b1}})) begin
                r_stall <= r_stall + 1'b1;
            end
            if (w_bubble_inc && (r_bubble != {CNTW{1'b1}})) begin
                r_bubble <= r_bubble + 1'b1;
            end
        end
    end

endmodule
